// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter with prescaler, pause and auto-reload. Counts Q
//   toward zero, one step every PRESCALE running cycles, and pulses done for
//   one cycle on expiry. Used for interval timing (serve delay, ball-speed
//   step interval, controller poll spacing).
//
// Parameters
//   WIDTH     width of Q and load_value
//   PRESCALE  clock cycles per decrement while running (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   load         load strobe, overrides everything else on its edge
//   load_value   value captured into Q and the reload register on load
//   ctrl         00 no-op, 01 start/resume, 10 pause, 11 abort
//   auto_reload  on expiry, reload from the saved value and keep running
//   busy         high while in RUN or PAUSE
//   done         one-cycle registered pulse on expiry
//   Q            current count
module countdown_timer #(
    parameter int WIDTH    = 10,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [1:0]       ctrl,
    input  logic             auto_reload,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_PAUSE = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] reload_reg, reload_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic             done_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            Q          <= '0;
            reload_reg <= '0;
            presc      <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            Q          <= q_nxt;
            reload_reg <= reload_nxt;
            presc      <= presc_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        q_nxt      = Q;
        reload_nxt = reload_reg;
        presc_nxt  = presc;
        done_nxt   = 1'b0;

        if (load) begin
            // Loading always parks the timer; a new start is needed.
            q_nxt      = load_value;
            reload_nxt = load_value;
            presc_nxt  = '0;
            state_nxt  = IDLE;
        end else if (ctrl == CMD_ABORT) begin
            // Abort wins even on an expiry edge, so no done pulse here.
            q_nxt     = '0;
            presc_nxt = '0;
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    // Starting from zero would expire instantly; ignore it.
                    if (ctrl == CMD_START && Q != '0) begin
                        state_nxt = RUN;
                        presc_nxt = '0;
                    end
                end
                RUN: begin
                    if (ctrl == CMD_PAUSE) begin
                        // Freeze on the pause edge even if a tick was due.
                        state_nxt = PAUSE;
                    end else if (presc == PS_LAST) begin
                        presc_nxt = '0;
                        if (Q > ONE) begin
                            q_nxt = Q - ONE;
                        end else if (auto_reload && reload_reg != '0) begin
                            q_nxt    = reload_reg;
                            done_nxt = 1'b1;
                        end else begin
                            q_nxt     = '0;
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        presc_nxt = presc + PW'(1);
                    end
                end
                PAUSE: begin
                    // Resume keeps the frozen prescaler phase.
                    if (ctrl == CMD_START) state_nxt = RUN;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
